// File: rtl/data_pipe_pkg.sv
// Shared types and helpers for the multi-source data pipe interconnect and its arbiter.
package data_pipe_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    SETTLE = 3'd2,
    GRANT  = 3'd3,
    DRAIN  = 3'd4
  } arb_state_t;

  // Connector plus one overflow buffer can hold at most two beats in flight.
  localparam int unsigned OUT_CNT_W = 2;
  localparam int unsigned OUT_MAX   = 2;

  function automatic int unsigned nsize_f(input int unsigned num);
    if (num <= 2) return 1;
    else if (num <= 4) return 2;
    else if (num <= 8) return 3;
    else if (num <= 16) return 4;
    else return 5;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set req bit starting at ptr+1, wrapping modulo NUM.
module rr_pick
  import data_pipe_pkg::*;
#(
  parameter int unsigned NUM   = 8,
  parameter int unsigned NSIZE = nsize_f(NUM)
) (
  input  logic [NUM-1:0]   req,
  input  logic [NSIZE-1:0] ptr,
  output logic [NSIZE-1:0] winner,
  output logic             any
);

  logic [NSIZE-1:0] idx;

  // Walk from the farthest candidate back to ptr+1 so the nearest one wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    any    = |req;
    for (int unsigned i = NUM; i > 0; i--) begin
      idx = NSIZE'((32'(ptr) + i) % NUM);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/data_pipe_rr_arbiter.sv
// Round-robin burst arbiter driving the interconnect path select; drains in-flight
// beats before every path switch.
module data_pipe_rr_arbiter
  import data_pipe_pkg::*;
#(
  parameter int unsigned NUM   = 8,
  parameter int unsigned BURST = 16,
  parameter int unsigned GAP   = 4,
  parameter int unsigned NSIZE = nsize_f(NUM)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [NUM-1:0]   req,
  input  logic             up_fire,
  input  logic             down_fire,
  input  logic [NSIZE-1:0] curr_path,
  output logic [NSIZE-1:0] sw,
  output logic             vld_sw,
  output logic [NUM-1:0]   grant,
  output logic             busy,
  output logic             err
);

  localparam int unsigned BW = $clog2(BURST) + 1;
  localparam int unsigned GW = $clog2(GAP) + 1;

  arb_state_t           state_q, state_d;
  logic [NSIZE-1:0]     sw_q, sw_d;
  logic [NSIZE-1:0]     ptr_q, ptr_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic                 err_q, err_d;

  logic [NSIZE-1:0] winner;
  logic             any_req;
  logic             req_sw;
  logic             last_fire;

  rr_pick #(.NUM(NUM), .NSIZE(NSIZE)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any_req)
  );

  assign req_sw    = req[sw_q];
  assign last_fire = up_fire && (bcnt_q == BW'(BURST - 1));

  always_comb begin
    state_d   = state_q;
    sw_d      = sw_q;
    ptr_d     = ptr_q;
    bcnt_d    = bcnt_q;
    gcnt_d    = gcnt_q;
    out_cnt_d = out_cnt_q;
    err_d     = err_q;
    vld_sw    = 1'b0;

    // Outstanding beats between the source handshake and the sink handshake.
    case ({up_fire, down_fire})
      2'b10: begin
        if (out_cnt_q == OUT_CNT_W'(OUT_MAX)) err_d = 1'b1;
        else out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
      end
      2'b01: begin
        if (out_cnt_q == '0) err_d = 1'b1;
        else out_cnt_d = out_cnt_q - OUT_CNT_W'(1);
      end
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        if (|req) state_d = ARB;
      end
      ARB: begin
        if (any_req) begin
          sw_d    = winner;
          ptr_d   = winner;
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        bcnt_d = '0;
        gcnt_d = '0;
        if (curr_path == sw_q) state_d = GRANT;
      end
      GRANT: begin
        // Dropped in the same cycle as the final beat so ready falls right after it.
        vld_sw = !last_fire;
        bcnt_d = bcnt_q + BW'(up_fire);
        gcnt_d = req_sw ? '0 : gcnt_q + GW'(1);
        if (last_fire || (!req_sw && gcnt_q == GW'(GAP - 1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_cnt_q == '0 && !up_fire) state_d = ARB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= IDLE;
      sw_q      <= '0;
      ptr_q     <= NSIZE'(NUM - 1);
      bcnt_q    <= '0;
      gcnt_q    <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      sw_q      <= sw_d;
      ptr_q     <= ptr_d;
      bcnt_q    <= bcnt_d;
      gcnt_q    <= gcnt_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == GRANT) grant[sw_q] = 1'b1;
  end

  assign sw   = sw_q;
  assign busy = (state_q != IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_data_pipe_rr_arbiter.sv
// Directed bench for data_pipe_rr_arbiter with a small behavioural interconnect
// (registered ready, two-deep outstanding storage, registered current path).
module tb_data_pipe_rr_arbiter;
  import data_pipe_pkg::*;

  localparam int unsigned NUM   = 4;
  localparam int unsigned BURST = 4;
  localparam int unsigned GAP   = 4;
  localparam int unsigned NSIZE = nsize_f(NUM);

  logic clk = 1'b0;
  logic rst, clk_en, sink_rdy, stale_hold, inj_down;
  logic [NUM-1:0] req;
  logic up_fire, down_fire;
  logic [NSIZE-1:0] curr_path, sw;
  logic vld_sw, busy, err;
  logic [NUM-1:0] grant;

  logic [1:0] occ, occ_nx;
  logic ready_q;

  int checks = 0;
  int failures = 0;

  int order_q[$];
  int beats_q[$];
  int cur_beats, max_occ, switch_bad;
  logic [NUM-1:0] prev_grant;
  logic [NSIZE-1:0] prev_sw;

  always #5 clk = ~clk;

  data_pipe_rr_arbiter #(.NUM(NUM), .BURST(BURST), .GAP(GAP), .NSIZE(NSIZE)) dut (
    .clock(clk), .rst(rst), .clk_en(clk_en), .req(req), .up_fire(up_fire),
    .down_fire(down_fire), .curr_path(curr_path), .sw(sw), .vld_sw(vld_sw),
    .grant(grant), .busy(busy), .err(err)
  );

  // Interconnect stand-in: ready follows vld_sw one cycle late and only while there is room.
  assign up_fire   = clk_en && ready_q && req[curr_path];
  assign down_fire = (clk_en && sink_rdy && occ != 2'd0) || inj_down;

  always_comb begin
    occ_nx = occ;
    if (up_fire && !(down_fire && occ != 2'd0)) occ_nx = occ + 2'd1;
    else if (!up_fire && down_fire && occ != 2'd0) occ_nx = occ - 2'd1;
  end

  always @(posedge clk) begin
    if (rst) begin
      occ <= 2'd0; ready_q <= 1'b0; curr_path <= '0;
    end else if (clk_en) begin
      occ <= occ_nx;
      ready_q <= vld_sw && (occ_nx < 2'd2);
      if (!stale_hold) curr_path <= sw;
    end
  end

  // Record grant order, beats per grant, peak occupancy and path switches with data in flight.
  always @(negedge clk) begin
    if (rst) begin
      order_q.delete(); beats_q.delete();
      cur_beats = 0; max_occ = 0; switch_bad = 0;
      prev_grant = '0; prev_sw = sw;
    end else begin
      if (grant != '0 && prev_grant == '0) begin order_q.push_back(int'(sw)); cur_beats = 0; end
      if (grant != '0 && up_fire) cur_beats++;
      if (grant == '0 && prev_grant != '0) beats_q.push_back(cur_beats);
      if (sw != prev_sw && occ != 2'd0) switch_bad++;
      if (int'(occ) > max_occ) max_occ = int'(occ);
      prev_grant = grant; prev_sw = sw;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0; clk_en = 1'b1; sink_rdy = 1'b1; stale_hold = 1'b0; inj_down = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (order_q.size() < n && k < budget) begin cyc(1); k++; end
    checks++;
    if (order_q.size() < n) begin
      failures++; $display("FAIL wait_grants: got %0d grants, required %0d", order_q.size(), n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (sw !== 2'd0) begin failures++; $display("FAIL reset_sw: got %0d required 0", sw); end
    checks++; if (vld_sw !== 1'b0) begin failures++; $display("FAIL reset_vld_sw: got %b required 0", vld_sw); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b required 0000", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b required 0", err); end
    req = 4'b0001;
    cyc(1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lat_busy_arb: got %b required 1", busy); end
    cyc(1);
    checks++; if (vld_sw !== 1'b0) begin failures++; $display("FAIL lat_vld_settle: got %b required 0", vld_sw); end
    cyc(1);
    checks++; if (vld_sw !== 1'b1) begin failures++; $display("FAIL lat_vld_grant: got %b required 1", vld_sw); end
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL lat_grant: got %b required 0001", grant); end
  endtask

  task automatic test_alternate();
    int exp_src[4] = '{0, 2, 0, 2};
    int got;
    apply_reset();
    req = 4'b0101;
    wait_grants(5, 300);
    for (int i = 0; i < 4; i++) begin
      got = (order_q.size() > i) ? order_q[i] : -1;
      checks++; if (got !== exp_src[i]) begin failures++; $display("FAIL alt_order[%0d]: got %0d required %0d", i, got, exp_src[i]); end
      got = (beats_q.size() > i) ? beats_q[i] : -1;
      checks++; if (got !== 4) begin failures++; $display("FAIL alt_beats[%0d]: got %0d required 4", i, got); end
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL alt_err: got %b required 0", err); end
    checks++; if (max_occ > 2) begin failures++; $display("FAIL alt_max_occ: got %0d required <=2", max_occ); end
    checks++; if (switch_bad !== 0) begin failures++; $display("FAIL alt_switch_in_flight: got %0d required 0", switch_bad); end
    req = '0;
  endtask

  task automatic test_gap();
    int n;
    int got;
    apply_reset();
    req = 4'b0010;
    n = 0;
    while (cur_beats < 2 && n < 60) begin cyc(1); n++; end
    req = '0;
    n = 0;
    while (grant != '0 && n < 20) begin cyc(1); n++; end
    checks++; if (n !== 4) begin failures++; $display("FAIL gap_hold_cycles: got %0d required 4", n); end
    cyc(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gap_back_to_idle: got %b required 0", busy); end
    got = (beats_q.size() > 0) ? beats_q[0] : -1;
    checks++; if (got !== 2) begin failures++; $display("FAIL gap_beats: got %0d required 2", got); end
    req = 4'b0010;
    wait_grants(2, 40);
    got = (order_q.size() > 1) ? order_q[1] : -1;
    checks++; if (got !== 1) begin failures++; $display("FAIL gap_regrant: got %0d required 1", got); end
    req = '0;
  endtask

  task automatic test_stall();
    int n;
    int got;
    apply_reset();
    req = 4'b0011;
    n = 0;
    while (cur_beats < 1 && n < 60) begin cyc(1); n++; end
    sink_rdy = 1'b0;
    cyc(10);
    checks++; if (sw !== 2'd0) begin failures++; $display("FAIL stall_sw: got %0d required 0", sw); end
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL stall_grant: got %b required 0001", grant); end
    checks++; if (max_occ !== 2) begin failures++; $display("FAIL stall_max_occ: got %0d required 2", max_occ); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL stall_err: got %b required 0", err); end
    sink_rdy = 1'b1;
    wait_grants(2, 100);
    got = (order_q.size() > 1) ? order_q[1] : -1;
    checks++; if (got !== 1) begin failures++; $display("FAIL stall_next_src: got %0d required 1", got); end
    got = (beats_q.size() > 0) ? beats_q[0] : -1;
    checks++; if (got !== 4) begin failures++; $display("FAIL stall_beats: got %0d required 4", got); end
    checks++; if (switch_bad !== 0) begin failures++; $display("FAIL stall_switch_in_flight: got %0d required 0", switch_bad); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL stall_err_end: got %b required 0", err); end
    req = '0;
  endtask

  task automatic test_settle();
    int first_hi = -1;
    logic vld5 = 1'b1;
    logic [NUM-1:0] grant6 = '0;
    apply_reset();
    req = 4'b0100;
    stale_hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) stale_hold = 1'b0;
      if (vld_sw === 1'b1 && first_hi < 0) first_hi = i;
      if (i == 5) vld5 = vld_sw;
      if (i == 6) grant6 = grant;
      cyc(1);
    end
    checks++; if (first_hi !== 6) begin failures++; $display("FAIL settle_first_vld: got cycle %0d required 6", first_hi); end
    checks++; if (vld5 !== 1'b0) begin failures++; $display("FAIL settle_vld_on_match: got %b required 0", vld5); end
    checks++; if (grant6 !== 4'b0100) begin failures++; $display("FAIL settle_grant: got %b required 0100", grant6); end
    req = '0;
  endtask

  task automatic test_clk_en();
    int exp_src[5] = '{0, 1, 2, 3, 0};
    int got;
    apply_reset();
    req = 4'b1111;
    for (int n = 0; n < 400 && order_q.size() < 5; n++) begin
      clk_en = ~clk_en;
      cyc(1);
    end
    clk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      got = (order_q.size() > i) ? order_q[i] : -1;
      checks++; if (got !== exp_src[i]) begin failures++; $display("FAIL clken_order[%0d]: got %0d required %0d", i, got, exp_src[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      got = (beats_q.size() > i) ? beats_q[i] : -1;
      checks++; if (got !== 4) begin failures++; $display("FAIL clken_beats[%0d]: got %0d required 4", i, got); end
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL clken_err: got %b required 0", err); end
    req = '0;
  endtask

  task automatic test_rst_mid();
    int n;
    int got;
    apply_reset();
    req = 4'b0100;
    n = 0;
    while (!(grant != '0 && occ == 2'd1) && n < 60) begin cyc(1); n++; end
    checks++; if (n >= 60) begin failures++; $display("FAIL rst_mid_reach_grant: got timeout required GRANT with one beat in flight"); end
    rst = 1'b1;
    cyc(1);
    checks++; if (sw !== 2'd0) begin failures++; $display("FAIL rst_mid_sw: got %0d required 0", sw); end
    checks++; if (vld_sw !== 1'b0) begin failures++; $display("FAIL rst_mid_vld_sw: got %b required 0", vld_sw); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b required 0", busy); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rst_mid_grant: got %b required 0000", grant); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_mid_err: got %b required 0", err); end
    rst = 1'b0;
    req = 4'b1111;
    wait_grants(1, 40);
    got = (order_q.size() > 0) ? order_q[0] : -1;
    checks++; if (got !== 0) begin failures++; $display("FAIL rst_mid_first_grant: got %0d required 0", got); end
    req = '0;
  endtask

  task automatic test_err();
    apply_reset();
    inj_down = 1'b1;
    cyc(1);
    inj_down = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_underflow: got %b required 1", err); end
    cyc(3);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b required 1", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL err_busy: got %b required 0", busy); end
    apply_reset();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared: got %b required 0", err); end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_gap();
    test_stall();
    test_settle();
    test_clk_en();
    test_rst_mid();
    test_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
